// File: rtl/mini_alu_16bit_mac_acc.sv
// mini_alu_16bit_mac_acc: saturating multiply-accumulate back end with valid/ready result register
module mini_alu_16bit_mac_acc #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      product,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, acc_base, add_acc;
  logic [CNT_W-1:0] count, count_nx, cnt_base, add_cnt;
  logic sat_flag, sat_nx, sat_base, add_sat;
  logic [ACC_W:0] sum;
  logic accept, close;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == HOLD;
  assign accept    = in_ready & in_valid;
  assign close     = accept & in_last;
  // clr takes effect before a same-cycle beat is added
  always_comb begin
    acc_base = clr ? '0 : acc;
    cnt_base = clr ? '0 : count;
    sat_base = clr ? 1'b0 : sat_flag;
    sum      = {1'b0, acc_base} + (ACC_W+1)'(product);
    add_acc  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    add_cnt  = &cnt_base ? cnt_base : cnt_base + 1'b1;
    add_sat  = sat_base | sum[ACC_W];
    state_nx = state;
    acc_nx   = acc;
    count_nx = count;
    sat_nx   = sat_flag;
    if (state == ACCUM) begin
      acc_nx   = accept ? add_acc : acc_base;
      count_nx = accept ? add_cnt : cnt_base;
      sat_nx   = accept ? add_sat : sat_base;
      state_nx = close ? HOLD : ACCUM;
    end else if (out_ready) begin
      acc_nx   = '0;
      count_nx = '0;
      sat_nx   = 1'b0;
      state_nx = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      sat_flag  <= 1'b0;
      acc_out   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      count    <= count_nx;
      sat_flag <= sat_nx;
      if (close) begin
        acc_out   <= add_acc;
        out_count <= add_cnt;
        out_sat   <= add_sat;
      end
    end
  end
endmodule

// File: tb/tb_mini_alu_16bit_mac_acc.sv
// tb_mini_alu_16bit_mac_acc: directed checks of grouping, saturation, clr, backpressure and reset
module tb_mini_alu_16bit_mac_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] product = '0;
  logic        in_last = 1'b0;
  logic        clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [39:0] acc_out;
  logic [7:0]  out_count;
  logic        out_sat;
  int n_vec = 0;
  int n_err = 0;

  mini_alu_16bit_mac_acc #(.ACC_W(40), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .in_last(in_last), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .out_count(out_count), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled on the falling edge
  task automatic beat(input logic [31:0] p, input logic last, input logic c);
    in_valid = 1'b1;
    product  = p;
    in_last  = last;
    clr      = c;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", out_valid); n_err++; end
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b want 1", in_ready); n_err++; end
    n_vec++; if (acc_out !== 40'd0) begin $display("FAIL reset_acc_out got %h want 0", acc_out); n_err++; end
    n_vec++; if (out_count !== 8'd0 || out_sat !== 1'b0) begin $display("FAIL reset_count_sat got %0d/%b want 0/0", out_count, out_sat); n_err++; end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    beat(32'd3, 1'b0, 1'b0);
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL basic_ready_mid got %b want 1", in_ready); n_err++; end
    beat(32'd5, 1'b0, 1'b0);
    beat(32'd7, 1'b1, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin $display("FAIL basic_hold got valid=%b ready=%b want 1/0", out_valid, in_ready); n_err++; end
    n_vec++; if (acc_out !== 40'd15) begin $display("FAIL basic_acc got %0d want 15", acc_out); n_err++; end
    n_vec++; if (out_count !== 8'd3 || out_sat !== 1'b0) begin $display("FAIL basic_count_sat got %0d/%b want 3/0", out_count, out_sat); n_err++; end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL basic_release got valid=%b ready=%b want 0/1", out_valid, in_ready); n_err++; end
  endtask

  task automatic test_single;
    beat(32'hFFFE0001, 1'b1, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || acc_out !== 40'h00FFFE0001) begin $display("FAIL single_acc got valid=%b acc=%h want 1/00fffe0001", out_valid, acc_out); n_err++; end
    n_vec++; if (out_count !== 8'd1 || out_sat !== 1'b0) begin $display("FAIL single_count_sat got %0d/%b want 1/0", out_count, out_sat); n_err++; end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    for (int i = 1; i <= 256; i++) beat(32'hFFFE0001, i == 256, 1'b0);
    n_vec++; if (acc_out !== 40'hFFFE000100 || out_sat !== 1'b0) begin $display("FAIL sat256_acc got %h/%b want fffe000100/0", acc_out, out_sat); n_err++; end
    n_vec++; if (out_count !== 8'd255) begin $display("FAIL sat256_count got %0d want 255", out_count); n_err++; end
    @(negedge clk);
    for (int i = 1; i <= 257; i++) beat(32'hFFFE0001, i == 257, 1'b0);
    n_vec++; if (acc_out !== 40'hFFFFFFFFFF) begin $display("FAIL sat257_acc got %h want ffffffffff", acc_out); n_err++; end
    n_vec++; if (out_sat !== 1'b1 || out_count !== 8'd255) begin $display("FAIL sat257_flag_count got %b/%0d want 1/255", out_sat, out_count); n_err++; end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    beat(32'd2, 1'b0, 1'b0);
    beat(32'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      product  = 32'd9;
      clr      = 1'b1;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 40'd5 || out_count !== 8'd2) begin
        $display("FAIL stall_%0d got valid=%b ready=%b acc=%0d cnt=%0d want 1/0/5/2", i, out_valid, in_ready, acc_out, out_count); n_err++;
      end
    end
    clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL stall_release got valid=%b ready=%b want 0/1", out_valid, in_ready); n_err++; end
    beat(32'd9, 1'b1, 1'b0);
    n_vec++; if (acc_out !== 40'd9 || out_count !== 8'd1) begin $display("FAIL stall_next_group got acc=%0d cnt=%0d want 9/1", acc_out, out_count); n_err++; end
    @(negedge clk);
  endtask

  task automatic test_clr;
    beat(32'd100, 1'b0, 1'b0);
    beat(32'd200, 1'b0, 1'b0);
    beat(32'd4, 1'b0, 1'b1);
    beat(32'd6, 1'b1, 1'b0);
    n_vec++; if (acc_out !== 40'd10 || out_count !== 8'd2 || out_sat !== 1'b0) begin $display("FAIL clr_group got acc=%0d cnt=%0d sat=%b want 10/2/0", acc_out, out_count, out_sat); n_err++; end
    @(negedge clk);
    beat(32'd50, 1'b0, 1'b0);
    beat(32'd8, 1'b1, 1'b1);
    n_vec++; if (acc_out !== 40'd8 || out_count !== 8'd1) begin $display("FAIL clr_last got acc=%0d cnt=%0d want 8/1", acc_out, out_count); n_err++; end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    beat(32'd1, 1'b0, 1'b0);
    beat(32'd1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL rst_mid got valid=%b ready=%b want 0/1", out_valid, in_ready); n_err++; end
    beat(32'd1, 1'b0, 1'b0);
    beat(32'd1, 1'b1, 1'b0);
    n_vec++; if (acc_out !== 40'd2 || out_count !== 8'd2) begin $display("FAIL rst_mid_group got acc=%0d cnt=%0d want 2/2", acc_out, out_count); n_err++; end
    @(negedge clk);
    out_ready = 1'b0;
    beat(32'd7, 1'b1, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || acc_out !== 40'd7) begin $display("FAIL rst_hold_pre got valid=%b acc=%0d want 1/7", out_valid, acc_out); n_err++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (out_valid !== 1'b0 || acc_out !== 40'd0) begin $display("FAIL rst_hold got valid=%b acc=%0d want 0/0", out_valid, acc_out); n_err++; end
    repeat (3) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL rst_hold_after got valid=%b ready=%b want 0/1", out_valid, in_ready); n_err++; end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single;
    test_saturation;
    test_backpressure;
    test_clr;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
